// File: rtl/pe_array_mc.sv
// Systolic PE array fed by two tag-multicast buses: images go down a column, weights across a row.
// Partial sums climb one row per cycle and leave through row 0.
module pe_array_mc #(
  parameter int ROWS = 12,
  parameter int COLS = 14,
  parameter int DW   = 16,
  parameter int PW   = 32,
  parameter int TW   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            image_val_in,
  input  logic [TW-1:0]            tag_col,
  input  logic                     valid_x,
  output logic                     ready_x,
  input  logic [DW-1:0]            weight_val_in,
  input  logic [TW-1:0]            tag_row,
  input  logic                     valid_y,
  output logic                     ready_y,
  input  logic [COLS-1:0][PW-1:0]  psum_ins,
  input  logic [COLS-1:0]          psum_in_valid,
  output logic [COLS-1:0][PW-1:0]  psum_outs,
  output logic [COLS-1:0]          psum_out_valid,
  output logic                     tag_err
);

  logic [COLS-1:0]           col_sel;
  logic [ROWS-1:0]           row_sel;
  logic [ROWS-1:0][COLS-1:0] w_vld;
  logic [ROWS-1:0][COLS-1:0] i_vld;
  logic [ROWS-1:0][COLS-1:0] pv_reg;
  logic [PW-1:0]             psum_reg [ROWS][COLS];
  logic                      acc_x;
  logic                      acc_y;

  // An out-of-range tag decodes to an all-zero select, so it touches no PE.
  always_comb begin
    for (int c = 0; c < COLS; c++) col_sel[c] = (int'(tag_col) == c);
    for (int r = 0; r < ROWS; r++) row_sel[r] = (int'(tag_row) == r);
  end

  // NOTE: both outputs get a default before the loop, so every path assigns them and no latch is inferred.
  always_comb begin
    ready_x = 1'b1;
    ready_y = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (i_vld[r][c] && col_sel[c]) ready_x = 1'b0;
        if (w_vld[r][c] && row_sel[r]) ready_y = 1'b0;
      end
    end
  end

  assign acc_x = valid_x && ready_x;
  assign acc_y = valid_y && ready_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_err <= 1'b0;
    end else if ((acc_x && !(|col_sel)) || (acc_y && !(|row_sel))) begin
      tag_err <= 1'b1;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [DW-1:0] w_q;
      logic [DW-1:0] i_q;
      logic          w_v;
      logic          i_v;
      logic          p_v;
      logic          fire;
      logic          below_v;
      logic [PW-1:0] p_q;
      logic [PW-1:0] below_p;
      logic [PW-1:0] prod;

      if (r == ROWS - 1) begin : g_bottom
        assign below_v = psum_in_valid[c];
        assign below_p = psum_in_valid[c] ? psum_ins[c] : '0;
      end else begin : g_inner
        assign below_v = pv_reg[r+1][c];
        assign below_p = psum_reg[r+1][c];
      end

      assign fire = w_v && i_v;
      assign prod = PW'(w_q) * PW'(i_q);

      // NOTE: operand registers carry no reset; the valid flags gate every use of them.
      always_ff @(posedge clk) begin
        if (acc_y && row_sel[r]) w_q <= weight_val_in;
        if (acc_x && col_sel[c]) i_q <= image_val_in;
      end

      // Ready backpressure guarantees an accept never lands on a flag that is firing.
      always_ff @(posedge clk) begin
        if (rst) begin
          w_v <= 1'b0;
          i_v <= 1'b0;
          p_q <= '0;
          p_v <= 1'b0;
        end else begin
          if (fire) begin
            w_v <= 1'b0;
            i_v <= 1'b0;
            p_q <= prod + below_p;
            p_v <= 1'b1;
          end else begin
            p_q <= below_p;
            p_v <= below_v;
          end
          if (acc_y && row_sel[r]) w_v <= 1'b1;
          if (acc_x && col_sel[c]) i_v <= 1'b1;
        end
      end

      assign w_vld[r][c]    = w_v;
      assign i_vld[r][c]    = i_v;
      assign pv_reg[r][c]   = p_v;
      assign psum_reg[r][c] = p_q;
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_out
    assign psum_outs[c]      = psum_reg[0][c];
    assign psum_out_valid[c] = pv_reg[0][c];
  end

endmodule
